burst_mem_responder: RTL and testbench
======================================

// Module: burst_mem_responder
// PURPOSE
// - Responder (memory) end of the 4x64-bit burst bus that the cacheline adaptor drives.
// - Synthesizable line-store model, used as the bmem stand-in for core-level sims and FPGA builds.
// - Accepts one request at a time: read (4 return beats) or write (4 data beats).
// - Backed by a 2**IDX_W x 256-bit array.
// PARAMETERS
// - IDX_W         6   line-index width; addr[5+IDX_W-1:5] selects the line; addr[4:0] ignored.
// - READ_LATENCY  4   cycles from read accept to first rvalid beat; legal >= 1.
// PORTS
// - clk          in   1    clock, rising edge
// - rst          in   1    reset, asynchronous, active-high
// - bmem_addr    in   32   request address; sampled on accept/beat 0 only
// - bmem_read    in   1    read request
// - bmem_write   in   1    write beat valid
// - bmem_wdata   in   64   write beat data
// - bmem_ready   out  1    responder can accept a read request or a write beat this cycle
// - bmem_raddr   out  32   address of the burst being returned; valid with rvalid
// - bmem_rdata   out  64   read beat data
// - bmem_rvalid  out  1    read beat valid
// BEHAVIOUR
// - Reset, async, while rst=1:
//   - rvalid=0, rdata=0, raddr=0; state=IDLE; all counters 0.
//   - bmem_ready=0 while rst=1.
//   - Array contents are not reset.
// - States: IDLE, WR, RD_WAIT, RD_BURST.
// - bmem_ready = !rst && (state==IDLE || state==WR); combinational from state.
// - IDLE:
//   - bmem_read=1 -> latch line addr; lat_cnt=READ_LATENCY-1; go RD_WAIT (or RD_BURST if READ_LATENCY==1).
//   - Otherwise bmem_write=1 -> latch addr and beat0 into wbuf[63:0]; beat_cnt=1; go WR.
//   - read+write in the same cycle: read wins; the write is ignored.
// - WR:
//   - bmem_write=1 -> store wdata at wbuf[64*beat_cnt +: 64]; beat_cnt++.
//   - Beat 3 commits all 256 bits to the array at that edge, then returns to IDLE.
//   - bmem_write=0 mid-burst -> abort: discard wbuf, no array update, go IDLE.
//   - bmem_read and bmem_addr are ignored in WR.
// - RD_WAIT: lat_cnt decrements each cycle; at 0 -> RD_BURST with beat_cnt=0.
// - RD_BURST:
//   - Registered outputs on 4 consecutive cycles: rvalid=1, rdata=line[64*k +: 64] for k=0..3.
//   - raddr = accepted addr with [4:0] cleared.
//   - After beat 3 -> IDLE; rvalid=0 the next cycle.
// - Timing (read accepted at the edge ending cycle T):
//   - beats visible in cycles T+READ_LATENCY .. T+READ_LATENCY+3.
//   - ready=1 again in cycle T+READ_LATENCY+4.
// - Read-after-write: a write committed at edge E is visible to a read accepted at any edge after E.
// - One outstanding request only; no backpressure on read beats (the initiator must sink 4 beats).
// - rst asserted mid-burst:
//   - rvalid drops immediately; partial write discarded; the array keeps its last committed state.
// - Widths: index truncation wraps; addresses 2**(IDX_W+5) apart alias to the same line.
// TESTING
// - Write 0x...0040 with beats 11,22,33,44 (64-bit), then read 0x40 (READ_LATENCY=4).
//   - Expect rdata 11,22,33,44 on 4 consecutive cycles starting 4 cycles after accept.
//   - Expect raddr=0x40 on every beat.
// - Read 0x5F after the above -> same 4 beats, raddr=0x40 (low bits ignored).
//   - ready=0 from the accept cycle+1 until beat 3 is done.
// - Write 0x80: beat0=AA, then bmem_write=0.
//   - Expect abort to IDLE; a read of 0x80 returns the prior contents, not AA.
// - read=1 and write=1 together in IDLE at 0xC0 -> read is serviced, no array write.
//   - Then a 4-beat write at 0xC0 followed by a read at 0xC0 -> new data.
// - Assert rst during RD_BURST beat 1 -> rvalid=0 the same cycle, ready=0 during rst.
//   - After release, ready=1 and a fresh read returns correct data.
// - READ_LATENCY=1 build: read accepted at T -> beat0 in T+1.
//   - Back-to-back read, read: second accept at T+5, no beat gaps or overlap.

Source files
------------

// File: rtl/burst_mem_responder_if.sv
// Burst bus between an initiator (cacheline adaptor) and the memory responder.
// One request at a time: a read returns four 64-bit beats, a write sends four 64-bit beats.
//   bmem_addr   request address, sampled on read accept / write beat 0
//   bmem_read   read request
//   bmem_write  write beat valid
//   bmem_wdata  write beat data
//   bmem_ready  responder accepts a read request or write beat this cycle
//   bmem_raddr  line address of the burst being returned (valid with rvalid)
//   bmem_rdata  read beat data
//   bmem_rvalid read beat valid
interface burst_mem_responder_if;
  logic [31:0] bmem_addr;
  logic        bmem_read;
  logic        bmem_write;
  logic [63:0] bmem_wdata;
  logic        bmem_ready;
  logic [31:0] bmem_raddr;
  logic [63:0] bmem_rdata;
  logic        bmem_rvalid;

  modport master (
    output bmem_addr,
    output bmem_read,
    output bmem_write,
    output bmem_wdata,
    input  bmem_ready,
    input  bmem_raddr,
    input  bmem_rdata,
    input  bmem_rvalid
  );

  modport slave (
    input  bmem_addr,
    input  bmem_read,
    input  bmem_write,
    input  bmem_wdata,
    output bmem_ready,
    output bmem_raddr,
    output bmem_rdata,
    output bmem_rvalid
  );
endinterface

// File: rtl/burst_mem_responder.sv
// Memory-side responder for the 4x64-bit burst bus; a synthesizable line store.
// Backed by a 2**IDX_W x 256-bit array; addr[5 +: IDX_W] selects the line, addr[4:0] ignored.
//   clk  rising-edge clock
//   rst  asynchronous active-high reset (array contents are kept)
//   bus  slave side of burst_mem_responder_if
// Reads return four registered beats starting READ_LATENCY cycles after accept.
// Writes collect four beats and commit the whole line on the fourth; a gap aborts the write.
module burst_mem_responder #(
  parameter int unsigned IDX_W        = 6,
  parameter int unsigned READ_LATENCY = 4
) (
  input logic                  clk,
  input logic                  rst,
  burst_mem_responder_if.slave bus
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StWr      = 2'd1;
  localparam logic [1:0] StRdWait  = 2'd2;
  localparam logic [1:0] StRdBurst = 2'd3;

  localparam int unsigned LatW  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam int unsigned Lines = 2 ** IDX_W;

  logic [1:0]       state_q, state_d;
  logic [1:0]       beat_q, beat_d;
  logic [LatW-1:0]  lat_q, lat_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      raddr_q, raddr_d;
  logic [63:0]      rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;
  // Beats 0..2 only; beat 3 goes straight from the bus into the array.
  logic [191:0]     wbuf_q, wbuf_d;

  logic [255:0]     mem_q [Lines];
  logic             mem_we;
  logic [255:0]     mem_wdata;

  logic [IDX_W-1:0] addr_idx;
  logic [255:0]     acc_line;
  logic [255:0]     cur_line;
  logic             unused_addr_bits;

  assign addr_idx         = bus.bmem_addr[5 +: IDX_W];
  assign acc_line         = mem_q[addr_idx];
  assign cur_line         = mem_q[idx_q];
  assign mem_wdata        = {bus.bmem_wdata, wbuf_q};
  assign unused_addr_bits = ^bus.bmem_addr[4:0];

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    lat_d    = lat_q;
    idx_d    = idx_q;
    raddr_d  = raddr_q;
    rdata_d  = rdata_q;
    rvalid_d = rvalid_q;
    wbuf_d   = wbuf_q;
    mem_we   = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.bmem_read) begin
          // Read wins over a simultaneous write.
          idx_d   = addr_idx;
          raddr_d = {bus.bmem_addr[31:5], 5'b0};
          beat_d  = 2'd0;
          if (READ_LATENCY == 1) begin
            state_d  = StRdBurst;
            rvalid_d = 1'b1;
            rdata_d  = acc_line[63:0];
          end else begin
            state_d = StRdWait;
            lat_d   = LatW'(READ_LATENCY - 1);
          end
        end else if (bus.bmem_write) begin
          idx_d         = addr_idx;
          wbuf_d        = '0;
          wbuf_d[63:0]  = bus.bmem_wdata;
          beat_d        = 2'd1;
          state_d       = StWr;
        end
      end

      StWr: begin
        if (bus.bmem_write) begin
          if (beat_q == 2'd3) begin
            mem_we  = 1'b1;
            beat_d  = 2'd0;
            wbuf_d  = '0;
            state_d = StIdle;
          end else begin
            if (beat_q == 2'd1) begin
              wbuf_d[127:64] = bus.bmem_wdata;
            end else begin
              wbuf_d[191:128] = bus.bmem_wdata;
            end
            beat_d = beat_q + 2'd1;
          end
        end else begin
          // Initiator dropped write mid-burst: abandon the line.
          beat_d  = 2'd0;
          wbuf_d  = '0;
          state_d = StIdle;
        end
      end

      StRdWait: begin
        lat_d = lat_q - 1'b1;
        // Load beat 0 on the edge where the counter reaches zero so it is registered in time.
        if (lat_q == LatW'(1)) begin
          state_d  = StRdBurst;
          beat_d   = 2'd0;
          rvalid_d = 1'b1;
          rdata_d  = cur_line[63:0];
        end
      end

      StRdBurst: begin
        // beat_q is the beat currently on rdata.
        if (beat_q == 2'd3) begin
          rvalid_d = 1'b0;
          beat_d   = 2'd0;
          state_d  = StIdle;
        end else begin
          beat_d  = beat_q + 2'd1;
          rdata_d = cur_line[64*beat_d +: 64];
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      beat_q   <= '0;
      lat_q    <= '0;
      idx_q    <= '0;
      raddr_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      wbuf_q   <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      lat_q    <= lat_d;
      idx_q    <= idx_d;
      raddr_q  <= raddr_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      wbuf_q   <= wbuf_d;
    end
  end

  // Array is deliberately not reset; mem_we is low whenever the FSM is held in reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[idx_q] <= mem_wdata;
    end
  end

  assign bus.bmem_ready  = !rst && ((state_q == StIdle) || (state_q == StWr));
  assign bus.bmem_raddr  = raddr_q;
  assign bus.bmem_rdata  = rdata_q;
  assign bus.bmem_rvalid = rvalid_q;

endmodule

// File: tb/tb_burst_mem_responder.sv
// Self-checking bench for burst_mem_responder: one instance with READ_LATENCY=4 and one with
// READ_LATENCY=1, selected by 'sel'. A line-level reference model tracks array contents.
module tb_burst_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic [31:0] addr;
  logic        rd;
  logic        wr;
  logic [63:0] wdata;

  logic        ready;
  logic        rvalid;
  logic [63:0] rdata;
  logic [31:0] raddr;

  int n_pass  = 0;
  int n_total = 0;
  int cur_lat = 4;

  logic [255:0] model_mem [2][64];
  bit           known     [2][64];

  always #5 clk = ~clk;

  burst_mem_responder_if bus_a ();
  burst_mem_responder_if bus_b ();

  assign bus_a.bmem_addr  = addr;
  assign bus_a.bmem_read  = rd & ~sel;
  assign bus_a.bmem_write = wr & ~sel;
  assign bus_a.bmem_wdata = wdata;
  assign bus_b.bmem_addr  = addr;
  assign bus_b.bmem_read  = rd & sel;
  assign bus_b.bmem_write = wr & sel;
  assign bus_b.bmem_wdata = wdata;

  assign ready  = sel ? bus_b.bmem_ready  : bus_a.bmem_ready;
  assign rvalid = sel ? bus_b.bmem_rvalid : bus_a.bmem_rvalid;
  assign rdata  = sel ? bus_b.bmem_rdata  : bus_a.bmem_rdata;
  assign raddr  = sel ? bus_b.bmem_raddr  : bus_a.bmem_raddr;

  burst_mem_responder #(.IDX_W(6), .READ_LATENCY(4)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  burst_mem_responder #(.IDX_W(6), .READ_LATENCY(1)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  function automatic logic [255:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Drives nbeats write beats starting at a negedge; nbeats<4 ends in an abort. Returns at a
  // negedge with the responder idle. Updates the model only for a full burst.
  task automatic do_write(input logic [31:0] a, input logic [255:0] line, input int nbeats,
                          output bit rdy_ok);
    int s;
    s      = sel ? 1 : 0;
    rdy_ok = 1'b1;
    for (int b = 0; b < nbeats; b++) begin
      addr  = (b == 0) ? a : $urandom();
      wr    = 1'b1;
      wdata = line[64*b +: 64];
      rd    = (b == 0) ? 1'b0 : 1'($urandom() % 2);
      if (ready !== 1'b1) rdy_ok = 1'b0;
      @(negedge clk);
    end
    wr = 1'b0;
    rd = 1'b0;
    if (nbeats < 4) @(negedge clk);
    if (nbeats == 4) begin
      model_mem[s][a[10:5]] = line;
      known[s][a[10:5]]     = 1'b1;
    end
  endtask

  // Issues a read at the current negedge and collects the burst. first is the cycle offset of
  // beat 0 from the accept cycle (-1 on timeout). proto = {ready at accept, ready while busy,
  // gap in beats, rvalid after beat 3, ready after beat 3}. Returns at the negedge after beat 3.
  task automatic do_read(input logic [31:0] a, input bit with_write, output int first,
                         output logic [255:0] got, output logic [127:0] raddrs,
                         output logic [4:0] proto);
    int  nb;
    bit  busy, gap, rva, rdya, accr, done;
    first = -1;
    nb    = 0;
    busy  = 1'b0;
    gap   = 1'b0;
    rva   = 1'b1;
    rdya  = 1'b0;
    done  = 1'b0;
    got    = '0;
    raddrs = '0;
    addr  = a;
    rd    = 1'b1;
    wr    = with_write;
    wdata = {$urandom(), $urandom()};
    accr  = (ready === 1'b1);
    @(negedge clk);
    rd   = 1'b0;
    wr   = 1'b0;
    addr = $urandom();
    for (int n = 1; n <= 40; n++) begin
      if (nb == 4) begin
        rva  = (rvalid !== 1'b0);
        rdya = (ready === 1'b1);
        done = 1'b1;
        break;
      end
      if (ready !== 1'b0) busy = 1'b1;
      if (rvalid === 1'b1) begin
        if (first < 0) first = n;
        got[64*nb +: 64]    = rdata;
        raddrs[32*nb +: 32] = raddr;
        nb++;
      end else if (nb > 0) begin
        gap = 1'b1;
      end
      @(negedge clk);
    end
    if (!done) first = -1;
    proto = {accr, busy, gap, rva, rdya};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sel = 1'b0;
    addr = '0; rd = 1'b0; wr = 1'b0; wdata = '0;
    @(negedge clk);
    @(negedge clk);
    n_total++; if (ready !== 1'b0) $display("FAIL reset_ready_a got %b want 0", ready); else n_pass++;
    n_total++; if (rvalid !== 1'b0) $display("FAIL reset_rvalid_a got %b want 0", rvalid); else n_pass++;
    n_total++; if (rdata !== 64'h0) $display("FAIL reset_rdata_a got %h want 0", rdata); else n_pass++;
    n_total++; if (raddr !== 32'h0) $display("FAIL reset_raddr_a got %h want 0", raddr); else n_pass++;
    sel = 1'b1;
    #1;
    n_total++; if (ready !== 1'b0) $display("FAIL reset_ready_b got %b want 0", ready); else n_pass++;
    n_total++; if (rvalid !== 1'b0) $display("FAIL reset_rvalid_b got %b want 0", rvalid); else n_pass++;
    sel = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_total++; if (ready !== 1'b1) $display("FAIL release_ready got %b want 1", ready); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    logic [255:0] line, got;
    logic [127:0] ra;
    logic [4:0]   proto;
    logic [31:0]  addrs [2];
    int           first;
    bit           ok;
    line = {64'h44, 64'h33, 64'h22, 64'h11};
    do_write(32'h0000_0040, line, 4, ok);
    n_total++; if (ok !== 1'b1) $display("FAIL wr_ready got %b want 1", ok); else n_pass++;
    addrs[0] = 32'h0000_0040;
    addrs[1] = 32'h0000_005F;
    for (int i = 0; i < 2; i++) begin
      do_read(addrs[i], 1'b0, first, got, ra, proto);
      n_total++; if (first !== cur_lat) $display("FAIL rd_latency[%0d] got %0d want %0d", i, first, cur_lat); else n_pass++;
      n_total++; if (got !== line) $display("FAIL rd_data[%0d] got %h want %h", i, got, line); else n_pass++;
      n_total++; if (ra !== {4{32'h0000_0040}}) $display("FAIL rd_raddr[%0d] got %h want %h", i, ra, {4{32'h0000_0040}}); else n_pass++;
      n_total++; if (proto !== 5'b10001) $display("FAIL rd_proto[%0d] got %b want 10001", i, proto); else n_pass++;
    end
  endtask

  task automatic test_abort();
    logic [255:0] prior, got;
    logic [127:0] ra;
    logic [4:0]   proto;
    int           first;
    bit           ok;
    prior = rand_line();
    do_write(32'h0000_0080, prior, 4, ok);
    do_write(32'h0000_0080, {4{64'hAA}}, 1, ok);
    n_total++; if (ok !== 1'b1) $display("FAIL abort_ready got %b want 1", ok); else n_pass++;
    do_read(32'h0000_0080, 1'b0, first, got, ra, proto);
    n_total++; if (got !== prior) $display("FAIL abort_data got %h want %h", got, prior); else n_pass++;
    n_total++; if (proto !== 5'b10001) $display("FAIL abort_proto got %b want 10001", proto); else n_pass++;
  endtask

  task automatic test_read_write_collision();
    logic [255:0] old_line, new_line, got;
    logic [127:0] ra;
    logic [4:0]   proto;
    int           first;
    bit           ok;
    old_line = rand_line();
    new_line = rand_line();
    do_write(32'h0000_00C0, old_line, 4, ok);
    do_read(32'h0000_00C0, 1'b1, first, got, ra, proto);
    n_total++; if (got !== old_line) $display("FAIL coll_data got %h want %h", got, old_line); else n_pass++;
    n_total++; if (first !== cur_lat) $display("FAIL coll_latency got %0d want %0d", first, cur_lat); else n_pass++;
    do_read(32'h0000_00C0, 1'b0, first, got, ra, proto);
    n_total++; if (got !== old_line) $display("FAIL coll_nowrite got %h want %h", got, old_line); else n_pass++;
    do_write(32'h0000_00C0, new_line, 4, ok);
    do_read(32'h0000_00C0, 1'b0, first, got, ra, proto);
    n_total++; if (got !== new_line) $display("FAIL coll_newdata got %h want %h", got, new_line); else n_pass++;
  endtask

  task automatic test_reset_mid_burst();
    logic [255:0] exp_line, got;
    logic [127:0] ra;
    logic [4:0]   proto;
    int           first, waited;
    exp_line = model_mem[0][2];
    addr = 32'h0000_0040;
    rd   = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    waited = 0;
    while (rvalid !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    n_total++; if (rvalid !== 1'b1) $display("FAIL rstmid_beat0 timeout rvalid %b want 1", rvalid); else n_pass++;
    @(negedge clk);
    n_total++; if (rdata !== exp_line[127:64]) $display("FAIL rstmid_beat1 got %h want %h", rdata, exp_line[127:64]); else n_pass++;
    #1 rst = 1'b1;
    #1;
    n_total++; if (rvalid !== 1'b0) $display("FAIL rstmid_rvalid got %b want 0", rvalid); else n_pass++;
    n_total++; if (ready !== 1'b0) $display("FAIL rstmid_ready got %b want 0", ready); else n_pass++;
    @(posedge clk);
    #1;
    n_total++; if (ready !== 1'b0) $display("FAIL rstmid_ready_held got %b want 0", ready); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_total++; if (ready !== 1'b1) $display("FAIL rstmid_release got %b want 1", ready); else n_pass++;
    @(negedge clk);
    do_read(32'h0000_0040, 1'b0, first, got, ra, proto);
    n_total++; if (got !== exp_line) $display("FAIL rstmid_reread got %h want %h", got, exp_line); else n_pass++;
    n_total++; if (proto !== 5'b10001) $display("FAIL rstmid_proto got %b want 10001", proto); else n_pass++;
    // Reset in the middle of a write must leave the committed line untouched.
    for (int b = 0; b < 3; b++) begin
      addr  = 32'h0000_0040;
      wr    = 1'b1;
      wdata = {$urandom(), $urandom()};
      if (b < 2) @(negedge clk);
    end
    #1 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wr  = 1'b0;
    @(negedge clk);
    do_read(32'h0000_0040, 1'b0, first, got, ra, proto);
    n_total++; if (got !== exp_line) $display("FAIL rstwr_data got %h want %h", got, exp_line); else n_pass++;
  endtask

  task automatic test_random();
    logic [255:0] line, got;
    logic [127:0] ra;
    logic [4:0]   proto;
    logic [31:0]  a, base;
    logic [5:0]   idx;
    int           first, op;
    bit           ok, coll;
    for (int it = 0; it < 40; it++) begin
      idx = 6'($urandom_range(0, 15));
      a   = {21'($urandom()), idx, 5'($urandom())};
      op  = $urandom_range(0, 3);
      if (op == 2) begin
        do_write(a, rand_line(), $urandom_range(1, 3), ok);
      end else if (op == 3 && known[0][idx]) begin
        coll = ($urandom() % 4) == 0;
        base = {a[31:5], 5'b0};
        do_read(a, coll, first, got, ra, proto);
        n_total++; if (first !== cur_lat) $display("FAIL rnd_latency it=%0d got %0d want %0d", it, first, cur_lat); else n_pass++;
        n_total++; if (got !== model_mem[0][idx]) $display("FAIL rnd_data it=%0d got %h want %h", it, got, model_mem[0][idx]); else n_pass++;
        n_total++; if (ra !== {4{base}}) $display("FAIL rnd_raddr it=%0d got %h want %h", it, ra, {4{base}}); else n_pass++;
        n_total++; if (proto !== 5'b10001) $display("FAIL rnd_proto it=%0d got %b want 10001", it, proto); else n_pass++;
      end else begin
        line = rand_line();
        do_write(a, line, 4, ok);
        n_total++; if (ok !== 1'b1) $display("FAIL rnd_wr_ready it=%0d got %b want 1", it, ok); else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back_lat1();
    logic [255:0] l0, l1, got;
    logic [127:0] ra;
    logic [4:0]   proto;
    logic [31:0]  addrs [3];
    logic [255:0] exps  [3];
    int           first;
    bit           ok;
    sel     = 1'b1;
    cur_lat = 1;
    @(negedge clk);
    l0 = rand_line();
    l1 = rand_line();
    do_write(32'h0000_0100, l0, 4, ok);
    do_write(32'h0000_02A0, l1, 4, ok);
    addrs[0] = 32'h0000_0100; exps[0] = l0;
    addrs[1] = 32'h0000_02A7; exps[1] = l1;
    addrs[2] = 32'h0000_0800 | 32'h0000_0100; exps[2] = l0;  // aliases index 8
    for (int i = 0; i < 3; i++) begin
      do_read(addrs[i], 1'b0, first, got, ra, proto);
      n_total++; if (first !== 1) $display("FAIL l1_latency[%0d] got %0d want 1", i, first); else n_pass++;
      n_total++; if (got !== exps[i]) $display("FAIL l1_data[%0d] got %h want %h", i, got, exps[i]); else n_pass++;
      n_total++; if (ra !== {4{addrs[i] & 32'hFFFF_FFE0}}) $display("FAIL l1_raddr[%0d] got %h want %h", i, ra, {4{addrs[i] & 32'hFFFF_FFE0}}); else n_pass++;
      n_total++; if (proto !== 5'b10001) $display("FAIL l1_proto[%0d] got %b want 10001", i, proto); else n_pass++;
    end
    sel     = 1'b0;
    cur_lat = 4;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_abort();
    test_read_write_collision();
    test_reset_mid_burst();
    test_random();
    test_back_to_back_lat1();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
